fp_align_prep: RTL

Pipelined pre-alignment stage of the fp32 adder. It sits directly upstream of the mantissa right-shifter. It unpacks two IEEE-754 single-precision operands and orders them by magnitude. It then computes the saturated exponent difference and delivers the larger and smaller 24-bit mantissas plus a 5-bit shift amount to the shifter, using a valid/ready handshake on both sides.

---
 rtl/fp_align_prep_if.sv | 28 ++
 rtl/fp_align_prep.sv | 102 ++++++++++
 2 files changed

// File: rtl/fp_align_prep_if.sv
// fp_align_prep_if: operand-pair input and aligned-pair output handshakes of the fp32 pre-alignment stage.
interface fp_align_prep_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] big_man;
    logic [23:0] small_man;
    logic [4:0]  shamt;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        eff_sub;
    logic        is_nan;
    logic        is_inf;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, big_man, small_man, shamt, exp_out, sign_out, eff_sub, is_nan, is_inf
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, big_man, small_man, shamt, exp_out, sign_out, eff_sub, is_nan, is_inf
    );
endinterface

// File: rtl/fp_align_prep.sv
// fp_align_prep: two-stage fp32 adder pre-alignment; unpacks operands, orders them by magnitude
// and produces the saturated shift amount for the downstream mantissa shifter.
module fp_align_prep #(
    parameter int SHAMT_MAX = 31
) (
    input logic           clk,
    input logic           rst,
    fp_align_prep_if.slave bus
);
    localparam logic [7:0] LP_MAX = 8'(SHAMT_MAX);

    logic        r_v1, r_sa, r_sb, r_nan_a, r_nan_b, r_inf_a, r_inf_b;
    logic [7:0]  r_ea, r_eb;
    logic [23:0] r_ma, r_mb;
    logic        r_v2, r_sign, r_eff_sub, r_is_nan, r_is_inf;
    logic [23:0] r_big_man, r_small_man;
    logic [4:0]  r_shamt;
    logic [7:0]  r_exp;
    logic        w_adv1, w_adv2, w_a_big, w_eff_sub, w_nan, w_inf, w_sign;
    logic [7:0]  w_diff;
    logic [4:0]  w_shamt;

    always_comb begin
        w_adv2    = !r_v2 | bus.out_ready;
        w_adv1    = !r_v1 | w_adv2;
        w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
        w_diff    = w_a_big ? r_ea - r_eb : r_eb - r_ea;
        w_shamt   = w_diff > LP_MAX ? LP_MAX[4:0] : w_diff[4:0];
        w_eff_sub = r_sa ^ r_sb;
        w_nan     = r_nan_a | r_nan_b | (r_inf_a & r_inf_b & w_eff_sub);
        w_inf     = !w_nan & (r_inf_a | r_inf_b);
        // A non-NaN pair of infinities always agrees in sign, so either Inf operand's sign is correct.
        w_sign    = w_inf ? (r_inf_a ? r_sa : r_sb) : (w_a_big ? r_sa : r_sb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ea    <= 8'd0;
            r_eb    <= 8'd0;
            r_ma    <= 24'd0;
            r_mb    <= 24'd0;
            r_nan_a <= 1'b0;
            r_nan_b <= 1'b0;
            r_inf_a <= 1'b0;
            r_inf_b <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_sa    <= bus.op_a[31];
                r_sb    <= bus.op_b[31] ^ bus.sub;
                r_ea    <= bus.op_a[30:23] == 8'd0 ? 8'd1 : bus.op_a[30:23];
                r_eb    <= bus.op_b[30:23] == 8'd0 ? 8'd1 : bus.op_b[30:23];
                r_ma    <= {bus.op_a[30:23] != 8'd0, bus.op_a[22:0]};
                r_mb    <= {bus.op_b[30:23] != 8'd0, bus.op_b[22:0]};
                r_nan_a <= (&bus.op_a[30:23]) & (|bus.op_a[22:0]);
                r_nan_b <= (&bus.op_b[30:23]) & (|bus.op_b[22:0]);
                r_inf_a <= (&bus.op_a[30:23]) & ~(|bus.op_a[22:0]);
                r_inf_b <= (&bus.op_b[30:23]) & ~(|bus.op_b[22:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2        <= 1'b0;
            r_big_man   <= 24'd0;
            r_small_man <= 24'd0;
            r_shamt     <= 5'd0;
            r_exp       <= 8'd0;
            r_sign      <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_is_nan    <= 1'b0;
            r_is_inf    <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_big_man   <= w_a_big ? r_ma : r_mb;
                r_small_man <= w_a_big ? r_mb : r_ma;
                r_shamt     <= w_shamt;
                r_exp       <= w_a_big ? r_ea : r_eb;
                r_sign      <= w_sign;
                r_eff_sub   <= w_eff_sub;
                r_is_nan    <= w_nan;
                r_is_inf    <= w_inf;
            end
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_v2;
    assign bus.big_man   = r_big_man;
    assign bus.small_man = r_small_man;
    assign bus.shamt     = r_shamt;
    assign bus.exp_out   = r_exp;
    assign bus.sign_out  = r_sign;
    assign bus.eff_sub   = r_eff_sub;
    assign bus.is_nan    = r_is_nan;
    assign bus.is_inf    = r_is_inf;
endmodule
